// File: rtl/riscv_result_checker.sv
// Purpose : compares qualified core results in order against a preloaded table of expected values.
// Latency : pass/fail/timeout are registered and appear one clk after the deciding result_valid edge.
// Backpressure: none; a result is sampled whenever result_valid is high, and there is no ready signal.
//
// Ports:
//   clk, reset                    rising-edge clock and asynchronous active-low reset
//   start                         begins a run; ignored while busy
//   result_valid, result          tapped core ALU result stream
//   exp_wr_en/_addr/_data         expected-table write port; ignored while busy
//   exp_count                     number of entries to check, sampled on start and clamped to DEPTH
//   busy, done, pass, fail        run status
//   timeout                       high when the failure was caused by a missing result
//   mismatch_idx/_got/_exp        first failing entry, observed value and expected value
//   cycle_count                   number of clk cycles spent running; saturates
module riscv_result_checker #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 50,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       result_valid,
    input  logic [DATA_W-1:0]          result,
    input  logic                       exp_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   exp_wr_addr,
    input  logic [DATA_W-1:0]          exp_wr_data,
    input  logic [$clog2(DEPTH+1)-1:0] exp_count,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic [$clog2(DEPTH)-1:0]   mismatch_idx,
    output logic [DATA_W-1:0]          mismatch_got,
    output logic [DATA_W-1:0]          mismatch_exp,
    output logic [CNT_W-1:0]           cycle_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [AW-1:0]     idx;
    logic [NW-1:0]     n;
    logic [TW-1:0]     timer;

    logic [DATA_W-1:0] exp_cur;
    logic [NW-1:0]     n_clamped;
    logic              is_last;
    logic [TW-1:0]     timer_inc;

    assign exp_cur   = exp_mem[idx];
    assign n_clamped = (exp_count > NW'(DEPTH)) ? NW'(DEPTH) : exp_count;
    // idx only advances while idx+1 < n, so it never wraps even for a full-depth run
    assign is_last   = (NW'(idx) + NW'(1)) == n;
    assign timer_inc = timer + TW'(1);

    // The table has no reset, so a run can be restarted after reset without reloading it.
    always_ff @(posedge clk) begin
        if (exp_wr_en && (state != S_RUN)) begin
            exp_mem[exp_wr_addr] <= exp_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            n            <= '0;
            timer        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            mismatch_idx <= '0;
            mismatch_got <= '0;
            mismatch_exp <= '0;
            cycle_count  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                    // A valid result wins over a timeout that would land in the same cycle.
                    if (result_valid) begin
                        if (result == exp_cur) begin
                            if (is_last) begin
                                state <= S_PASS;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= 1'b1;
                            end else begin
                                idx   <= idx + AW'(1);
                                timer <= '0;
                            end
                        end else begin
                            state        <= S_FAIL;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            fail         <= 1'b1;
                            mismatch_idx <= idx;
                            mismatch_got <= result;
                            mismatch_exp <= exp_cur;
                        end
                    end else if (timer_inc == TW'(TIMEOUT)) begin
                        state        <= S_FAIL;
                        timer        <= timer_inc;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        fail         <= 1'b1;
                        timeout      <= 1'b1;
                        mismatch_idx <= idx;
                        mismatch_got <= '0;
                        mismatch_exp <= exp_cur;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: begin
                    // IDLE, PASS and FAIL hold until start; results seen here are ignored.
                    if (start) begin
                        n            <= n_clamped;
                        idx          <= '0;
                        timer        <= '0;
                        cycle_count  <= '0;
                        timeout      <= 1'b0;
                        mismatch_idx <= '0;
                        mismatch_got <= '0;
                        mismatch_exp <= '0;
                        fail         <= 1'b0;
                        if (n_clamped == '0) begin
                            state <= S_PASS;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_result_checker.sv
module tb_riscv_result_checker;

    localparam int DATA_W  = 64;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 50;
    localparam int CNT_W   = 32;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic              clk;
    logic              reset;
    logic              start;
    logic              result_valid;
    logic [63:0]       result;
    logic              exp_wr_en;
    logic [3:0]        exp_wr_addr;
    logic [63:0]       exp_wr_data;
    logic [4:0]        exp_count;
    logic              busy, done, pass, fail, timeout;
    logic [3:0]        mismatch_idx;
    logic [63:0]       mismatch_got, mismatch_exp;
    logic [31:0]       cycle_count;

    int checks   = 0;
    int failures = 0;

    riscv_result_checker #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .result_valid(result_valid), .result(result),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .exp_count(exp_count),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .mismatch_idx(mismatch_idx), .mismatch_got(mismatch_got),
        .mismatch_exp(mismatch_exp), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got=%h required=%h", nm, got, req);
        end
    endtask

    // One clock edge; returns 1 time unit after it so outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [63:0] d);
        exp_wr_en   = 1'b1;
        exp_wr_addr = 4'(a);
        exp_wr_data = d;
        step();
        exp_wr_en   = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] c);
        exp_count = c;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic drive(input logic [63:0] v);
        result_valid = 1'b1;
        result       = v;
        step();
        result_valid = 1'b0;
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    function automatic logic [63:0] tv(input int i);
        case (i)
            0:       return 64'h5;
            1:       return 64'hA;
            2:       return ONES;
            default: return 64'hC0DE_0000_0000_0000 | 64'(i);
        endcase
    endfunction

    task automatic load_tv();
        for (int i = 0; i < DEPTH; i++) wr(i, tv(i));
    endtask

    typedef struct packed {
        logic [4:0]       cnt;
        logic [2:0]       nres;
        logic [3:0][63:0] res;
        logic             e_pass;
        logic             e_fail;
        logic [3:0]       e_idx;
        logic [63:0]      e_got;
        logic [63:0]      e_exp;
        logic [31:0]      e_cyc;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] c, input int nr,
                                input logic [63:0] r0, r1, r2, r3,
                                input logic p, f, input int ix,
                                input logic [63:0] g, e, input int cyc);
        vec_t v;
        v.cnt = c; v.nres = 3'(nr);
        v.res[0] = r0; v.res[1] = r1; v.res[2] = r2; v.res[3] = r3;
        v.e_pass = p; v.e_fail = f; v.e_idx = 4'(ix);
        v.e_got = g; v.e_exp = e; v.e_cyc = 32'(cyc);
        return v;
    endfunction

    vec_t vt[7];

    // reference model state for randomized runs
    logic [63:0] model [DEPTH];
    int          gap   [DEPTH];
    logic [63:0] val   [DEPTH];

    initial begin
        reset = 1'b0; start = 1'b0; result_valid = 1'b0; result = '0;
        exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0; exp_count = '0;

        vt[0] = mk(5'd3, 3, 64'h5, 64'hA, ONES, 64'h0,             1, 0, 0, 64'h0, 64'h0, 3);
        vt[1] = mk(5'd3, 2, 64'h5, 64'hB, 64'h0, 64'h0,            0, 1, 1, 64'hB, 64'hA, 2);
        vt[2] = mk(5'd1, 1, 64'h5, 64'h0, 64'h0, 64'h0,            1, 0, 0, 64'h0, 64'h0, 1);
        vt[3] = mk(5'd4, 4, 64'h5, 64'hA, ONES, 64'hC0DE_0000_0000_0003, 1, 0, 0, 64'h0, 64'h0, 4);
        vt[4] = mk(5'd2, 1, 64'h6, 64'h0, 64'h0, 64'h0,            0, 1, 0, 64'h6, 64'h5, 1);
        vt[5] = mk(5'd4, 3, 64'h5, 64'hA, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0,
                   0, 1, 2, 64'hFFFF_FFFF_FFFF_FFFE, ONES, 3);
        vt[6] = mk(5'd0, 0, 64'h0, 64'h0, 64'h0, 64'h0,            1, 0, 0, 64'h0, 64'h0, 0);

        #12;
        chk("reset_flags", {59'd0, busy, done, pass, fail, timeout}, 64'd0);
        chk("reset_cycle_count", 64'(cycle_count), 64'd0);
        reset = 1'b1;
        step();
        load_tv();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 7; i++) begin
            // a result coinciding with start must be ignored
            result_valid = 1'b1;
            result       = 64'hDEAD;
            start_run(vt[i].cnt);
            result_valid = 1'b0;
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].cnt != 5'd0));
            for (int j = 0; j < int'(vt[i].nres); j++) drive(vt[i].res[j]);
            chk($sformatf("v%0d_pass", i), 64'(pass), 64'(vt[i].e_pass));
            chk($sformatf("v%0d_fail", i), 64'(fail), 64'(vt[i].e_fail));
            chk($sformatf("v%0d_done", i), 64'(done), 64'(vt[i].e_pass | vt[i].e_fail));
            chk($sformatf("v%0d_timeout", i), 64'(timeout), 64'd0);
            chk($sformatf("v%0d_midx", i), 64'(mismatch_idx), 64'(vt[i].e_idx));
            chk($sformatf("v%0d_mgot", i), mismatch_got, vt[i].e_got);
            chk($sformatf("v%0d_mexp", i), mismatch_exp, vt[i].e_exp);
            chk($sformatf("v%0d_cycles", i), 64'(cycle_count), 64'(vt[i].e_cyc));
            // sticky verdict: later results ignored, cycle_count frozen
            drive({$urandom, $urandom});
            drive(64'h5);
            chk($sformatf("v%0d_sticky", i), {62'd0, pass, fail},
                {62'd0, vt[i].e_pass, vt[i].e_fail});
            chk($sformatf("v%0d_frozen", i), 64'(cycle_count), 64'(vt[i].e_cyc));
        end

        // ---------------- timeout at exactly TIMEOUT cycles ----------------
        start_run(5'd3);
        idle_steps(TIMEOUT - 1);
        chk("to_not_yet", {62'd0, busy, fail}, 64'b10);
        step();
        chk("to_fail", {61'd0, fail, timeout, busy}, 64'b110);
        chk("to_midx", 64'(mismatch_idx), 64'd0);
        chk("to_mgot", mismatch_got, 64'd0);
        chk("to_mexp", mismatch_exp, 64'h5);
        chk("to_cycles", 64'(cycle_count), 64'(TIMEOUT));

        // valid in the cycle the timer would expire wins; next entry then times out
        start_run(5'd3);
        idle_steps(TIMEOUT - 1);
        drive(64'h5);
        chk("to_saved", {62'd0, busy, fail}, 64'b10);
        idle_steps(TIMEOUT);
        chk("to2_fail", {62'd0, fail, timeout}, 64'b11);
        chk("to2_midx", 64'(mismatch_idx), 64'd1);
        chk("to2_mexp", mismatch_exp, 64'hA);
        chk("to2_cycles", 64'(cycle_count), 64'(2 * TIMEOUT));

        // ---------------- exp_count above DEPTH clamps to DEPTH ----------------
        start_run(5'(DEPTH + 5));
        for (int i = 0; i < DEPTH - 1; i++) drive(tv(i));
        chk("full_not_yet", {62'd0, busy, pass}, 64'b10);
        drive(tv(DEPTH - 1));
        chk("full_pass", {62'd0, pass, fail}, 64'b10);
        chk("full_cycles", 64'(cycle_count), 64'(DEPTH));

        // ---------------- asynchronous reset mid-run ----------------
        start_run(5'd3);
        drive(64'h5);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_flags", {59'd0, busy, done, pass, fail, timeout}, 64'd0);
        chk("arst_cycles", 64'(cycle_count), 64'd0);
        chk("arst_midx", 64'(mismatch_idx), 64'd0);
        step();
        #2;
        reset = 1'b1;
        step();
        start_run(5'd3);
        drive(64'h5); drive(64'hA); drive(ONES);
        chk("arst_restart_pass", {62'd0, pass, fail}, 64'b10);
        chk("arst_restart_cycles", 64'(cycle_count), 64'd3);

        // ---------------- table write and start ignored during RUN ----------------
        start_run(5'd3);
        drive(64'h5);
        exp_wr_en = 1'b1; exp_wr_addr = 4'd2; exp_wr_data = 64'h99;
        start = 1'b1;
        step();
        exp_wr_en = 1'b0; start = 1'b0;
        drive(64'hA);
        drive(ONES);
        chk("runwr_pass", {62'd0, pass, fail}, 64'b10);
        chk("runwr_cycles", 64'(cycle_count), 64'd4);

        // ---------------- randomized runs against an event-level model ----------------
        for (int i = 0; i < DEPTH; i++) model[i] = tv(i);
        for (int r = 0; r < 40; r++) begin
            int cnt, n, nev, elapsed, r_cyc, r_idx;
            logic r_pass, r_fail, r_to, decided;
            logic [63:0] r_got, r_exp;

            for (int k = 0; k < 4; k++) begin
                int a;
                logic [63:0] d;
                a = $urandom_range(0, DEPTH - 1);
                d = {$urandom, $urandom};
                wr(a, d);
                model[a] = d;
            end
            cnt = $urandom_range(0, DEPTH + 3);
            n   = (cnt > DEPTH) ? DEPTH : cnt;
            nev = (n > 0 && $urandom_range(0, 9) == 0) ? n - 1 : n;
            for (int j = 0; j < nev; j++) begin
                gap[j] = ($urandom_range(0, 19) == 0) ? $urandom_range(TIMEOUT - 3, TIMEOUT + 3)
                                                      : $urandom_range(0, 3);
                val[j] = ($urandom_range(0, 9) == 0)
                         ? (model[j] ^ (64'd1 << $urandom_range(0, 63))) : model[j];
            end

            r_pass = 0; r_fail = 0; r_to = 0; decided = 0;
            r_idx = 0; r_got = '0; r_exp = '0; elapsed = 0; r_cyc = 0;
            if (n == 0) begin
                r_pass = 1; decided = 1;
            end
            for (int j = 0; j < nev && !decided; j++) begin
                if (gap[j] >= TIMEOUT) begin
                    r_fail = 1; r_to = 1; r_idx = j; r_exp = model[j];
                    r_cyc = elapsed + TIMEOUT; decided = 1;
                end else begin
                    elapsed += gap[j] + 1;
                    if (val[j] != model[j]) begin
                        r_fail = 1; r_idx = j; r_got = val[j]; r_exp = model[j];
                        r_cyc = elapsed; decided = 1;
                    end else if (j == n - 1) begin
                        r_pass = 1; r_cyc = elapsed; decided = 1;
                    end
                end
            end
            if (!decided) begin
                r_fail = 1; r_to = 1; r_idx = nev; r_exp = model[nev];
                r_cyc = elapsed + TIMEOUT;
            end

            start_run(5'(cnt));
            for (int j = 0; j < nev; j++) begin
                result = {$urandom, $urandom};
                idle_steps(gap[j]);
                drive(val[j]);
            end
            for (int w = 0; w < TIMEOUT + 10 && !done; w++) step();

            chk($sformatf("rnd%0d_verdict", r), {60'd0, done, pass, fail, timeout},
                {60'd0, 1'b1, r_pass, r_fail, r_to});
            chk($sformatf("rnd%0d_midx", r), 64'(mismatch_idx), 64'(r_idx));
            chk($sformatf("rnd%0d_mgot", r), mismatch_got, r_got);
            chk($sformatf("rnd%0d_mexp", r), mismatch_exp, r_exp);
            chk($sformatf("rnd%0d_cycles", r), 64'(cycle_count), 64'(r_cyc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
